// File: rtl/moving_sum_win.sv
// Sliding-window sum and mean over the last LEN accepted samples.
// Define MOVING_SUM_ROUND_EN to round avg to nearest instead of floor.
module moving_sum_win #(
  parameter  int DW  = 8,
  parameter  int LEN = 32,
  localparam int SW  = DW + $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [SW-1:0] sum,
  output logic [DW-1:0] avg,
  output logic          full,
  output logic          upd
);

  localparam int AW = $clog2(LEN);

  generate
    if (LEN < 2 || (LEN & (LEN - 1)) != 0) begin : g_bad_len
      $error("moving_sum_win: LEN must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic {FILL, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   wp_q;
  logic [SW-1:0]   sum_q, sum_d;
  logic            upd_q;
  logic [DW-1:0]   mem [LEN];
  logic [DW-1:0]   out;
  logic            acc;

  assign acc = en & ~clr & ~rst;

  // Stale buffer words are masked until the window has really filled.
  assign out = (state_q == RUN) ? mem[wp_q] : '0;

  assign sum_d = SW'({1'b0, sum_q}
               + (SW+1)'(din)
               - (SW+1)'(out));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == (AW+1)'(LEN))
            state_d = RUN;
        end
      end
      RUN: state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= FILL;
      cnt_q   <= '0;
      wp_q    <= '0;
      sum_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd_q   <= en;
      if (en) begin
        wp_q  <= wp_q + 1'b1;
        sum_q <= sum_d;
      end
    end
  end

  // Read of mem[wp_q] above sees the old word; the write lands at the edge.
  always_ff @(posedge clk) begin
    if (acc)
      mem[wp_q] <= din;
  end

`ifdef MOVING_SUM_ROUND_EN
  logic [SW:0] rnd;
  logic [SW:0] rq;

  assign rnd = {1'b0, sum_q} + (SW+1)'(LEN / 2);
  assign rq  = rnd >> AW;

  always_comb begin
    avg = DW'(rq);
    if (rq > (SW+1)'({DW{1'b1}}))
      avg = '1;
  end
`else
  assign avg = sum_q[SW-1:AW];
`endif

  assign sum  = sum_q;
  assign full = (state_q == RUN);
  assign upd  = upd_q;

endmodule

// File: tb/tb_moving_sum_win.sv
// Randomised and directed bench for moving_sum_win at LEN=4 and LEN=32.
module tb_moving_sum_win;

  logic        clk = 1'b0;
  logic        rst;
  logic        en4, clr4, en32, clr32;
  logic [7:0]  din4, din32;
  logic [9:0]  sum4;
  logic [12:0] sum32;
  logic [7:0]  avg4, avg32;
  logic        full4, full32, upd4, upd32;

  int errs = 0;
  int checks = 0;
  int q4[$];
  int q32[$];
  int eupd4, eupd32;

  always #5 clk = ~clk;

  moving_sum_win #(.DW(8), .LEN(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr4), .din(din4),
    .sum(sum4), .avg(avg4), .full(full4), .upd(upd4)
  );

  moving_sum_win #(.DW(8), .LEN(32)) u32 (
    .clk(clk), .rst(rst), .en(en32), .clr(clr32), .din(din32),
    .sum(sum32), .avg(avg32), .full(full32), .upd(upd32)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int mavg(input int s, input int len);
    int r;
`ifdef MOVING_SUM_ROUND_EN
    r = (s + len / 2) / len;
    if (r > 255) r = 255;
`else
    r = s / len;
`endif
    return r;
  endfunction

  task automatic model();
    if (rst) begin
      q4.delete(); q32.delete();
      eupd4 = 0; eupd32 = 0;
    end else begin
      if (clr4) begin
        q4.delete(); eupd4 = 0;
      end else if (en4) begin
        q4.push_back(int'(din4)); eupd4 = 1;
        if (q4.size() > 4) void'(q4.pop_front());
      end else eupd4 = 0;
      if (clr32) begin
        q32.delete(); eupd32 = 0;
      end else if (en32) begin
        q32.push_back(int'(din32)); eupd32 = 1;
        if (q32.size() > 32) void'(q32.pop_front());
      end else eupd32 = 0;
    end
  endtask

  task automatic tick();
    int s;
    @(posedge clk);
    model();
    #1;
    s = qsum(q4);
    chk("sum4", int'(sum4), s);
    chk("avg4", int'(avg4), mavg(s, 4));
    chk("full4", int'(full4), int'(q4.size() == 4));
    chk("upd4", int'(upd4), eupd4);
    s = qsum(q32);
    chk("sum32", int'(sum32), s);
    chk("avg32", int'(avg32), mavg(s, 32));
    chk("full32", int'(full32), int'(q32.size() == 32));
    chk("upd32", int'(upd32), eupd32);
  endtask

  task automatic idle();
    rst = 0; en4 = 0; clr4 = 0; din4 = 0;
    en32 = 0; clr32 = 0; din32 = 0;
  endtask

  task automatic put4(input int v);
    en4 = 1; din4 = 8'(v);
    tick();
    en4 = 0;
  endtask

  task automatic clear4();
    clr4 = 1; tick(); clr4 = 0;
  endtask

  initial begin
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_sum4", int'(sum4), 0);
    chk("rst_full32", int'(full32), 0);
    rst = 0;

    put4(10); put4(20); put4(30);
    chk("fill_full_early", int'(full4), 0);
    put4(40);
    chk("fill_sum", int'(sum4), 100);
    chk("fill_avg", int'(avg4), 25);
    chk("fill_full", int'(full4), 1);
    put4(50);
    chk("wrap_sum1", int'(sum4), 140);
    chk("wrap_avg1", int'(avg4), 35);
    put4(60);
    chk("wrap_sum2", int'(sum4), 180);
    chk("wrap_avg2", int'(avg4), 45);

    clear4();
    foreach (pat[i]) begin
      en4 = pat[i][0]; din4 = 8'd7;
      tick();
    end
    en4 = 0;
    chk("gap_sum", int'(sum4), 28);

    clear4();
    put4(10); put4(20); put4(30); put4(40);
    clr4 = 1; en4 = 1; din4 = 8'd99;
    tick();
    clr4 = 0; en4 = 0;
    chk("clr_sum", int'(sum4), 0);
    chk("clr_full", int'(full4), 0);
    put4(5);
    chk("clr_refill", int'(sum4), 5);

    clear4();
    put4(1); put4(1); put4(1); put4(3);
`ifdef MOVING_SUM_ROUND_EN
    chk("round_avg", int'(avg4), 2);
`else
    chk("round_avg", int'(avg4), 1);
`endif

    for (int i = 0; i < 40; i++) begin
      en32 = 1; din32 = 8'd255;
      tick();
    end
    en32 = 0;
    chk("max_sum", int'(sum32), 8160);
    chk("max_avg", int'(avg32), 255);
    chk("max_full", int'(full32), 1);

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en4   = $urandom_range(0, 3) != 0;
      clr4  = ($urandom_range(0, 29) == 0);
      din4  = 8'($urandom);
      en32  = $urandom_range(0, 3) != 0;
      clr32 = ($urandom_range(0, 99) == 0);
      din32 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
